fpmult_pipe: RTL and testbench

//  Parametrised IEEE-754-style floating-point multiplier; successor to the single-precision block.
//  3-stage pipeline with valid/ready handshake and back-pressure, round-to-nearest-even, and full special-case handling.

---
 rtl/fpmult_pkg.sv | 28 ++
 rtl/fpmult_if.sv | 34 +++
 rtl/fpmult_round.sv | 76 +++++++
 rtl/fpmult_pipe.sv | 163 ++++++++++++++++
 tb/tb_fpmult_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpmult_pkg.sv
// fpmult_pkg: shared constants and helpers for the fpmult pipeline.
// Class codes, flag bit positions, bias/limit and canonical qNaN builders.
package fpmult_pkg;

   localparam logic [1:0] CLS_ZERO = 2'd0;
   localparam logic [1:0] CLS_NORM = 2'd1;
   localparam logic [1:0] CLS_INF  = 2'd2;
   localparam logic [1:0] CLS_NAN  = 2'd3;

   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;

   function automatic int bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

   function automatic int exp_max(input int ew);
      return (1 << ew) - 1;
   endfunction

   // Positive sign, all-ones exponent, only the fraction MSB set.
   function automatic logic [63:0] qnan(input int ew, input int mw);
      return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
   endfunction

endpackage

// File: rtl/fpmult_if.sv
// fpmult_if: operand/result handshake bundle for fpmult_pipe.
// The flags signal exists only when FPMULT_FLAGS_EN is defined.
interface fpmult_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
`ifdef FPMULT_FLAGS_EN
   logic [3:0]   flags;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, y, flags
   );
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, y, flags
   );
`else
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, y
   );
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, y
   );
`endif
endinterface

// File: rtl/fpmult_round.sv
// fpmult_round: normalise, round-to-nearest-even, range check and pack.
// Flag outputs are present only when FPMULT_FLAGS_EN is defined.
module fpmult_round
   import fpmult_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   i_sign,
   input  logic [EXP_W+1:0]       i_e,
   input  logic [2*MAN_W+1:0]     i_p,
   input  logic                   i_spec,
   input  logic [EXP_W+MAN_W:0]   i_spec_y,
`ifdef FPMULT_FLAGS_EN
   input  logic                   i_inv,
   output logic [3:0]             o_flags,
`endif
   output logic [EXP_W+MAN_W:0]   o_y
);

   localparam int PW  = 2 * MAN_W + 2;
   localparam int EW2 = EXP_W + 2;
   localparam logic [EXP_W:0] EMAX = (EXP_W + 1)'(exp_max(EXP_W));

   logic [PW-2:0]    w_pn;
   logic [MAN_W-1:0] w_frac;
   logic [MAN_W-1:0] w_frac_r;
   logic             w_g;
   logic             w_s;
   logic             w_up;
   logic             w_cy;
   logic [EW2-1:0]   w_e1;
   logic             w_ovf;
   logic             w_unf;

   // Product lies in [1,4); drop the leading one after normalising.
   assign w_pn   = i_p[PW-1] ? i_p[PW-2:0] : {i_p[PW-3:0], 1'b0};
   assign w_frac = w_pn[PW-2 -: MAN_W];
   assign w_g    = w_pn[MAN_W];
   assign w_s    = |w_pn[MAN_W-1:0];
   assign w_up   = w_g & (w_s | w_frac[0]);

   assign {w_cy, w_frac_r} = {1'b0, w_frac} + (MAN_W + 1)'(w_up);

   assign w_e1  = i_e + EW2'(i_p[PW-1]) + EW2'(w_cy);
   assign w_ovf = ~w_e1[EW2-1] & (w_e1[EXP_W:0] >= EMAX);
   assign w_unf = w_e1[EW2-1] | (w_e1 == '0);

   always_comb begin
      o_y = {i_sign, w_e1[EXP_W-1:0], w_frac_r};
      if (i_spec)
         o_y = i_spec_y;
      else if (w_ovf)
         o_y = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (w_unf)
         o_y = {i_sign, {(EXP_W + MAN_W){1'b0}}};
   end

`ifdef FPMULT_FLAGS_EN
   always_comb begin
      o_flags = '0;
      if (i_spec) begin
         o_flags[FLG_INV] = i_inv;
      end else if (w_ovf) begin
         o_flags[FLG_OVF] = 1'b1;
         o_flags[FLG_INX] = 1'b1;
      end else if (w_unf) begin
         o_flags[FLG_UNF] = 1'b1;
         o_flags[FLG_INX] = 1'b1;
      end else begin
         o_flags[FLG_INX] = w_g | w_s;
      end
   end
`endif

endmodule

// File: rtl/fpmult_pipe.sv
// fpmult_pipe: 3-stage parametrised FP multiplier with valid/ready back-pressure.
// Define FPMULT_FLAGS_EN to add the {invalid,overflow,underflow,inexact} flags port.
module fpmult_pipe
   import fpmult_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic     clk,
   input logic     rst,
   fpmult_if.slave bus
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int MW  = MAN_W + 1;
   localparam int PW  = 2 * MW;
   localparam int EW2 = EXP_W + 2;
   localparam logic [EW2-1:0] BIAS_E = EW2'(bias(EXP_W));
   localparam logic [W-1:0]   QNAN   = W'(qnan(EXP_W, MAN_W));

   function automatic logic [1:0] cls(input logic [EXP_W-1:0] e,
                                      input logic [MAN_W-1:0] f);
      if (e == '0) return CLS_ZERO;
      if (&e) return (f == '0) ? CLS_INF : CLS_NAN;
      return CLS_NORM;
   endfunction

   logic [1:0]     w_ca, w_cb;
   logic           w_sign;
   logic [EW2-1:0] w_e;
   logic           w_nan_case;
   logic           w_spec;
   logic [W-1:0]   w_spec_y;
   logic           w_rdy1, w_rdy2, w_rdy3;
   logic [W-1:0]   w_y;

   logic           r1_v, r1_sign, r1_spec;
   logic [MW-1:0]  r1_ma, r1_mb;
   logic [EW2-1:0] r1_e;
   logic [W-1:0]   r1_spec_y;
   logic           r2_v, r2_sign, r2_spec;
   logic [PW-1:0]  r2_p;
   logic [EW2-1:0] r2_e;
   logic [W-1:0]   r2_spec_y;
   logic           r3_v;
   logic [W-1:0]   r3_y;
`ifdef FPMULT_FLAGS_EN
   logic           r1_inv, r2_inv;
   logic [3:0]     w_flags, r3_flags;
`endif

   assign w_ca   = cls(bus.a[W-2 -: EXP_W], bus.a[MAN_W-1:0]);
   assign w_cb   = cls(bus.b[W-2 -: EXP_W], bus.b[MAN_W-1:0]);
   assign w_sign = bus.a[W-1] ^ bus.b[W-1];
   assign w_e    = EW2'(bus.a[W-2 -: EXP_W]) + EW2'(bus.b[W-2 -: EXP_W]) - BIAS_E;

   assign w_nan_case = (w_ca == CLS_NAN) | (w_cb == CLS_NAN) |
                       (w_ca == CLS_INF & w_cb == CLS_ZERO) |
                       (w_ca == CLS_ZERO & w_cb == CLS_INF);

   always_comb begin
      w_spec   = 1'b1;
      w_spec_y = {w_sign, {(W - 1){1'b0}}};
      if (w_nan_case)
         w_spec_y = QNAN;
      else if (w_ca == CLS_INF || w_cb == CLS_INF)
         w_spec_y = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (w_ca != CLS_ZERO && w_cb != CLS_ZERO)
         w_spec = 1'b0;
   end

   // Each stage may advance when empty or when its successor advances.
   assign w_rdy3 = ~r3_v | bus.out_ready;
   assign w_rdy2 = ~r2_v | w_rdy3;
   assign w_rdy1 = ~r1_v | w_rdy2;

   assign bus.in_ready  = w_rdy1;
   assign bus.out_valid = r3_v;
   assign bus.y         = r3_y;

   fpmult_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round (
      .i_sign   (r2_sign),
      .i_e      (r2_e),
      .i_p      (r2_p),
      .i_spec   (r2_spec),
      .i_spec_y (r2_spec_y),
`ifdef FPMULT_FLAGS_EN
      .i_inv    (r2_inv),
      .o_flags  (w_flags),
`endif
      .o_y      (w_y)
   );

`ifdef FPMULT_FLAGS_EN
   assign bus.flags = r3_flags;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r1_v      <= 1'b0;
         r1_sign   <= 1'b0;
         r1_spec   <= 1'b0;
         r1_ma     <= '0;
         r1_mb     <= '0;
         r1_e      <= '0;
         r1_spec_y <= '0;
         r2_v      <= 1'b0;
         r2_sign   <= 1'b0;
         r2_spec   <= 1'b0;
         r2_p      <= '0;
         r2_e      <= '0;
         r2_spec_y <= '0;
         r3_v      <= 1'b0;
         r3_y      <= '0;
`ifdef FPMULT_FLAGS_EN
         r1_inv    <= 1'b0;
         r2_inv    <= 1'b0;
         r3_flags  <= '0;
`endif
      end else begin
         if (w_rdy1) begin
            r1_v <= bus.in_valid;
            if (bus.in_valid) begin
               r1_sign   <= w_sign;
               r1_spec   <= w_spec;
               r1_spec_y <= w_spec_y;
               r1_ma     <= {1'b1, bus.a[MAN_W-1:0]};
               r1_mb     <= {1'b1, bus.b[MAN_W-1:0]};
               r1_e      <= w_e;
`ifdef FPMULT_FLAGS_EN
               r1_inv    <= w_nan_case;
`endif
            end
         end
         if (w_rdy2) begin
            r2_v <= r1_v;
            if (r1_v) begin
               r2_sign   <= r1_sign;
               r2_spec   <= r1_spec;
               r2_spec_y <= r1_spec_y;
               r2_p      <= PW'(r1_ma) * PW'(r1_mb);
               r2_e      <= r1_e;
`ifdef FPMULT_FLAGS_EN
               r2_inv    <= r1_inv;
`endif
            end
         end
         if (w_rdy3) begin
            r3_v <= r2_v;
            if (r2_v) begin
               r3_y <= w_y;
`ifdef FPMULT_FLAGS_EN
               r3_flags <= w_flags;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_fpmult_pipe.sv
// tb_fpmult_pipe: scoreboard bench for fpmult_pipe (single and half precision).
// Flag checks are active when FPMULT_FLAGS_EN is defined.
module tb_fpmult_pipe;

   typedef struct {
      logic [31:0] y;
      logic [3:0]  f;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fpmult_if #(.W(32)) bus ();
   fpmult_if #(.W(16)) hbus ();

   fpmult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fpmult_pipe #(.EXP_W(5), .MAN_W(10)) hdut (
      .clk (clk),
      .rst (rst),
      .bus (hbus)
   );

   exp_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;
   int   n_out  = 0;

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst && bus.out_valid && bus.out_ready) begin
         n_run++;
         n_out++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected got=%h required=none", bus.y);
         end else begin
            e = sb.pop_front();
            if (bus.y !== e.y) begin
               n_fail++;
               $display("FAIL sb_y#%0d got=%h required=%h", n_out, bus.y, e.y);
            end
`ifdef FPMULT_FLAGS_EN
            n_run++;
            if (bus.flags !== e.f) begin
               n_fail++;
               $display("FAIL sb_flags#%0d got=%b required=%b", n_out, bus.flags, e.f);
            end
`endif
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ey, input logic [3:0] ef);
      int k = 0;
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && k < 50) begin
         k++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         n_run++;
         n_fail++;
         $display("FAIL send_timeout got=in_ready0 required=in_ready1");
      end else begin
         sb.push_back('{ey, ef});
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 100) begin
         @(posedge clk);
         k++;
      end
      #1;
      n_run++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain got=%0d pending required=0", sb.size());
      end
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a = '0;
      bus.b = '0;
      hbus.in_valid  = 1'b0;
      hbus.out_ready = 1'b1;
      hbus.a = '0;
      hbus.b = '0;
      rst = 1'b0;
      #3;
      n_run += 3;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out_valid got=%b required=0", bus.out_valid);
      end
      if (bus.y !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_y got=%h required=0", bus.y);
      end
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready got=%b required=1", bus.in_ready);
      end
`ifdef FPMULT_FLAGS_EN
      n_run++;
      if (bus.flags !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_flags got=%b required=0", bus.flags);
      end
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      send(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
      n_run++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_c1 got=%b required=0", bus.out_valid);
      end
      @(posedge clk);
      #1;
      n_run++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_c2 got=%b required=0", bus.out_valid);
      end
      @(posedge clk);
      #1;
      n_run++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL latency_c3 got=%b required=1", bus.out_valid);
      end
      drain();
   endtask

   task automatic test_round();
      send(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
      send(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000);
      send(32'h3F800001, 32'h3FC00001, 32'h3FC00003, 4'b0001);
      send(32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000);
      drain();
   endtask

   task automatic test_special();
      send(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
      send(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
      send(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
      send(32'h80000000, 32'h40000000, 32'h80000000, 4'b0000);
      send(32'h00000001, 32'h40000000, 32'h00000000, 4'b0000);
      drain();
   endtask

   task automatic test_range();
      send(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
      send(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
      send(32'hFF000000, 32'h7F000000, 32'hFF800000, 4'b0101);
      drain();
   endtask

   task automatic test_back_to_back();
      logic [31:0] ta[6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                             32'h40800000, 32'h40A00000, 32'h40C00000};
      logic [31:0] ty[6] = '{32'h40000000, 32'h40800000, 32'h40C00000,
                             32'h41000000, 32'h41200000, 32'h41400000};
      logic [31:0] held;
      bus.out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(ta[i], 32'h40000000, ty[i], 4'b0000);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            n_run += 3;
            if (bus.in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_in_ready got=%b required=0", bus.in_ready);
            end
            if (sb.size() != 3) begin
               n_fail++;
               $display("FAIL stall_accepted got=%0d required=3", sb.size());
            end
            if (bus.out_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL stall_out_valid got=%b required=1", bus.out_valid);
            end
            held = bus.y;
            @(posedge clk);
            #1;
            n_run += 2;
            if (bus.y !== held || bus.y !== 32'h40000000) begin
               n_fail++;
               $display("FAIL stall_y_hold got=%h required=%h", bus.y, 32'h40000000);
            end
            if (bus.in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_in_ready2 got=%b required=0", bus.in_ready);
            end
            bus.out_ready = 1'b1;
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               n_run++;
               if (bus.out_valid !== 1'b1) begin
                  n_fail++;
                  $display("FAIL b2b_gap%0d got=%b required=1", i, bus.out_valid);
               end
               if (i == 0) begin
                  n_run++;
                  if (bus.in_ready !== 1'b1) begin
                     n_fail++;
                     $display("FAIL full_pass got=%b required=1", bus.in_ready);
                  end
               end
            end
         end
      join
      drain();
   endtask

   task automatic test_reset_flight();
      send(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
      send(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
      @(posedge clk);
      #2;
      n_run++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL flight_pre got=%b required=1", bus.out_valid);
      end
      rst = 1'b0;
      #1;
      n_run += 2;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flight_rst_valid got=%b required=0", bus.out_valid);
      end
      if (bus.y !== 32'h0) begin
         n_fail++;
         $display("FAIL flight_rst_y got=%h required=0", bus.y);
      end
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_run++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_out%0d got=%b required=0", i, bus.out_valid);
         end
      end
      @(posedge clk);
      #1;
      send(32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);
      drain();
   endtask

   task automatic test_half();
      logic [15:0] ha[2] = '{16'h3E00, 16'h7BFF};
      logic [15:0] hy[2] = '{16'h4200, 16'h7C00};
      logic [3:0]  hf[2] = '{4'b0000, 4'b0101};
      int k;
      for (int i = 0; i < 2; i++) begin
         hbus.a = ha[i];
         hbus.b = (i == 0) ? 16'h4000 : 16'h7BFF;
         hbus.in_valid = 1'b1;
         @(posedge clk);
         #1 hbus.in_valid = 1'b0;
         k = 0;
         @(negedge clk);
         while (!hbus.out_valid && k < 20) begin
            k++;
            @(negedge clk);
         end
         n_run++;
         if (hbus.out_valid !== 1'b1 || hbus.y !== hy[i]) begin
            n_fail++;
            $display("FAIL half_y%0d got=%h required=%h", i, hbus.y, hy[i]);
         end
`ifdef FPMULT_FLAGS_EN
         n_run++;
         if (hbus.flags !== hf[i]) begin
            n_fail++;
            $display("FAIL half_flags%0d got=%b required=%b", i, hbus.flags, hf[i]);
         end
`endif
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round();
      test_special();
      test_range();
      test_back_to_back();
      test_reset_flight();
      test_half();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
